// File: rtl/bsi_pkg.sv
// Shared types for the shift/rotate unit and the arbiter that fronts it.
package bsi_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_t;

endpackage

// File: rtl/bsi.sv
// Combinational shifter with a fixed configuration.
// RIGHT selects the direction, ARITH sign-fills right shifts, ROTATE
// turns a right shift into a rotate. The shift amount is SHIFT_W bits,
// so it is implicitly taken modulo W.
module bsi #(
    parameter int W       = 32,
    parameter int SHIFT_W = $clog2(W),
    parameter bit RIGHT   = 1'b0,
    parameter bit ARITH   = 1'b0,
    parameter bit ROTATE  = 1'b0
) (
    input  logic [W-1:0]       x,
    input  logic [SHIFT_W-1:0] shamt,
    output logic [W-1:0]       y
);

    generate
        if (ROTATE) begin : g_ror
            // Rotating right is the low half of {x,x} shifted right.
            assign y = W'({x, x} >> shamt);
        end else if (RIGHT && ARITH) begin : g_sra
            logic signed [W-1:0] xs;
            assign xs = $signed(x);
            assign y  = $unsigned(xs >>> shamt);
        end else if (RIGHT) begin : g_srl
            assign y = x >> shamt;
        end else begin : g_sll
            assign y = x << shamt;
        end
    endgenerate

endmodule

// File: rtl/rr_arb.sv
// Round-robin arbiter: grants the first requesting index at or after ptr,
// wrapping modulo N. The encoded index is always reported; the one-hot
// grant is only asserted when en is high and someone is requesting.
module rr_arb #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic            en,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] idx
);

    logic found;
    int   k;

    // Scan the request vector starting at ptr and pick the first requester.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) k = k - N;
            if (!found && req[k]) begin
                found = 1'b1;
                idx   = ID_W'(k);
            end
        end
        if (found && en) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/bsi_arb.sv
// Shares one registered shift/rotate datapath between N requesters.
// A round-robin arbiter grants at most one request per cycle; the result is
// captured in a single output slot and presented one cycle later, tagged with
// the requester index. The slot reloads in the same cycle it drains, so a
// continuously-ready consumer sees one result per cycle.
module bsi_arb
    import bsi_pkg::*;
#(
    parameter int W       = 32,
    parameter int N       = 4,
    parameter int SHIFT_W = $clog2(W),
    parameter int ID_W    = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_valid_i,
    output logic [N-1:0]         req_ready_o,
    input  logic [N*OP_W-1:0]    req_op_i,
    input  logic [N*W-1:0]       req_x_i,
    input  logic [N*SHIFT_W-1:0] req_shift_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [W-1:0]         rsp_y_o,
    output logic [ID_W-1:0]      rsp_id_o,
    output logic                 busy_o
);

    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    gidx;
    logic [N-1:0]       gnt;
    logic               can_accept;
    logic               fire;
    logic [ID_W-1:0]    next_ptr;

    op_t                op_sel;
    logic [W-1:0]       x_sel;
    logic [SHIFT_W-1:0] sh_sel;
    logic [W-1:0]       y_sll;
    logic [W-1:0]       y_srl;
    logic [W-1:0]       y_sra;
    logic [W-1:0]       y_ror;
    logic [W-1:0]       y_next;

    // The slot can take a new result when empty or when it drains this cycle.
    // Gating with rst_n keeps req_ready_o low while reset is held.
    assign can_accept = (!rsp_valid_o || rsp_ready_i) && rst_n;

    rr_arb #(
        .N    (N),
        .ID_W (ID_W)
    ) u_rr_arb (
        .req (req_valid_i),
        .ptr (ptr),
        .en  (can_accept),
        .gnt (gnt),
        .idx (gidx)
    );

    assign req_ready_o = gnt;
    assign fire        = |gnt;
    assign next_ptr    = (gidx == ID_W'(N - 1)) ? '0 : gidx + 1'b1;
    assign busy_o      = rsp_valid_o | (|req_valid_i);

    // Only the granted requester's fields reach the shifters, so unknowns on
    // idle requesters cannot leak into the result.
    assign op_sel = op_t'(req_op_i[gidx*OP_W +: OP_W]);
    assign x_sel  = req_x_i[gidx*W +: W];
    assign sh_sel = req_shift_i[gidx*SHIFT_W +: SHIFT_W];

    bsi #(.W(W), .SHIFT_W(SHIFT_W), .RIGHT(1'b0), .ARITH(1'b0), .ROTATE(1'b0))
        u_sll (.x(x_sel), .shamt(sh_sel), .y(y_sll));
    bsi #(.W(W), .SHIFT_W(SHIFT_W), .RIGHT(1'b1), .ARITH(1'b0), .ROTATE(1'b0))
        u_srl (.x(x_sel), .shamt(sh_sel), .y(y_srl));
    bsi #(.W(W), .SHIFT_W(SHIFT_W), .RIGHT(1'b1), .ARITH(1'b1), .ROTATE(1'b0))
        u_sra (.x(x_sel), .shamt(sh_sel), .y(y_sra));
    bsi #(.W(W), .SHIFT_W(SHIFT_W), .RIGHT(1'b1), .ARITH(1'b0), .ROTATE(1'b1))
        u_ror (.x(x_sel), .shamt(sh_sel), .y(y_ror));

    // Select the shifter output matching the granted op.
    always_comb begin
        y_next = y_sll;
        case (op_sel)
            OP_SLL:  y_next = y_sll;
            OP_SRL:  y_next = y_srl;
            OP_SRA:  y_next = y_sra;
            OP_ROR:  y_next = y_ror;
            default: y_next = y_sll;
        endcase
    end

    // Output slot and round-robin pointer: load on transfer, clear on drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_o <= 1'b0;
            rsp_y_o     <= '0;
            rsp_id_o    <= '0;
            ptr         <= '0;
        end else if (fire) begin
            rsp_valid_o <= 1'b1;
            rsp_y_o     <= y_next;
            rsp_id_o    <= gidx;
            ptr         <= next_ptr;
        end else if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
        end
    end

endmodule
